// File: rtl/wb_pkg.sv
// Shared types for the write-back port arbiter: default widths, buffered
// multi-cycle result entry and the arbiter FSM state encoding.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding multi-cycle results until the write port is free.
// Head is read combinationally so a pop reaches the output register in one cycle.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [DEPTH-1:0] slot_we;
    logic             do_push;
    logic             do_pop;
    entry_t           mem [DEPTH];

    // Flags come from the registered count only, so a full buffer refuses a
    // push even while it is being popped.
    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_we[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order pipeline and a
// buffered multi-cycle unit, forcing a one-cycle pipeline stall on starvation.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic              mem_to_reg,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] MemoryData,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_rd,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] RegWriteData
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    wb_arb_state_e     state_reg;
    wb_arb_state_e     state_next;
    logic [CNT_W-1:0]  starve_cnt_reg;
    logic [CNT_W-1:0]  starve_cnt_next;

    logic              buf_full;
    logic              buf_empty;
    logic              buf_push;
    entry_t            push_entry;
    entry_t            head_entry;

    logic              grant_pipe;
    logic              grant_buf;
    logic              grant_any;
    logic [DATA_W-1:0] pipe_data;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    assign mc_ready        = !buf_full;
    assign buf_push        = mc_valid && mc_ready;
    assign push_entry.rd   = mc_rd;
    assign push_entry.data = mc_data;

    wb_result_fifo #(
        .entry_t (entry_t),
        .DEPTH   (BUF_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data (push_entry),
        .pop       (grant_buf),
        .head      (head_entry),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Pipeline has priority in NORMAL; FORCE hands the port to the buffer head.
    always_comb begin
        grant_pipe = 1'b0;
        grant_buf  = 1'b0;
        case (state_reg)
            NORMAL: begin
                grant_pipe = wb_en;
                grant_buf  = !wb_en && !buf_empty;
            end
            FORCE: begin
                grant_buf = !buf_empty;
            end
            default: begin
                grant_pipe = 1'b0;
                grant_buf  = 1'b0;
            end
        endcase
    end

    assign grant_any = grant_pipe || grant_buf;
    assign pipe_data = mem_to_reg ? MemoryData : alu_result;
    assign win_rd    = grant_buf ? head_entry.rd : pipe_rd;
    assign win_data  = grant_buf ? head_entry.data : pipe_data;

    // Counts pipeline wins while something is waiting in the buffer.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_buf || buf_empty) begin
            starve_cnt_next = '0;
        end else if (grant_pipe) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NORMAL:  state_next = (starve_cnt_next == STARVE_LIM) ? FORCE : NORMAL;
            FORCE:   state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    // pipe_stall is registered alongside the state so it is a clean Moore output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= NORMAL;
            starve_cnt_reg <= '0;
            pipe_stall     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            pipe_stall     <= (state_next == FORCE);
        end
    end

    // Writes to x0 still consume the grant but never assert the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            RegWriteData <= '0;
        end else begin
            rf_we <= grant_any && (win_rd != '0);
            if (grant_any) begin
                rf_waddr     <= win_rd;
                RegWriteData <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, mux, idle drain, starvation,
// full buffer back-pressure, x0 writes and reset discarding queued results.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_en = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] MemoryData = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_data = '0;
    logic        mc_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] RegWriteData;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .BUF_DEPTH  (2),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_en        (wb_en),
        .mem_to_reg   (mem_to_reg),
        .pipe_rd      (pipe_rd),
        .alu_result   (alu_result),
        .MemoryData   (MemoryData),
        .mc_valid     (mc_valid),
        .mc_rd        (mc_rd),
        .mc_data      (mc_data),
        .mc_ready     (mc_ready),
        .pipe_stall   (pipe_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .RegWriteData (RegWriteData)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we) $display("[%0t] write x%0d = %h stall=%b", $time, rf_waddr, RegWriteData, pipe_stall);
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got time %0t, want under 100000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en      = 1'b0;
        mc_valid   = 1'b0;
        mem_to_reg = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_en      = 1'($urandom);
            mem_to_reg = 1'($urandom);
            pipe_rd    = 5'($urandom);
            alu_result = $urandom;
            MemoryData = $urandom;
            mc_valid   = 1'($urandom);
            mc_rd      = 5'($urandom);
            mc_data    = $urandom;
            tick();
            n_cmp++;
            if ({rf_we, rf_waddr, RegWriteData, pipe_stall, mc_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got we=%b addr=%0d data=%h stall=%b ready=%b, want 0/0/0/0/1",
                         i, rf_we, rf_waddr, RegWriteData, pipe_stall, mc_ready);
            end
        end
        idle_inputs();
        reset      = 1'b1;
        wb_en      = 1'b1;
        pipe_rd    = 5'd3;
        alu_result = 32'h10;
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData} !== {1'b1, 5'd3, 32'h10}) begin
            n_err++;
            $display("FAIL first_write: got we=%b addr=%0d data=%h, want 1/3/00000010", rf_we, rf_waddr, RegWriteData);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mux();
        wb_en      = 1'b1;
        mem_to_reg = 1'b1;
        pipe_rd    = 5'd9;
        MemoryData = 32'hDEAD;
        alu_result = 32'h1;
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData} !== {1'b1, 5'd9, 32'hDEAD}) begin
            n_err++;
            $display("FAIL mux_mem: got we=%b addr=%0d data=%h, want 1/9/0000dead", rf_we, rf_waddr, RegWriteData);
        end
        mem_to_reg = 1'b0;
        pipe_rd    = 5'd10;
        alu_result = 32'h1234;
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData} !== {1'b1, 5'd10, 32'h1234}) begin
            n_err++;
            $display("FAIL mux_alu: got we=%b addr=%0d data=%h, want 1/10/00001234", rf_we, rf_waddr, RegWriteData);
        end
        idle_inputs();
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData} !== {1'b0, 5'd10, 32'h1234}) begin
            n_err++;
            $display("FAIL idle_hold: got we=%b addr=%0d data=%h, want 0/10/00001234", rf_we, rf_waddr, RegWriteData);
        end
    endtask

    task automatic test_idle_drain();
        n_cmp++;
        if (mc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL drain_ready: got %b, want 1", mc_ready);
        end
        mc_valid = 1'b1;
        mc_rd    = 5'd7;
        mc_data  = 32'h55;
        tick();
        mc_valid = 1'b0;
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL drain_n1: got we=%b, want 0", rf_we);
        end
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData} !== {1'b1, 5'd7, 32'h55}) begin
            n_err++;
            $display("FAIL drain_n2: got we=%b addr=%0d data=%h, want 1/7/00000055", rf_we, rf_waddr, RegWriteData);
        end
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL drain_once: got we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_starvation();
        int   drv_k[6]  = '{2, 3, 4, 5, 6, 6};
        int   exp_rd[6] = '{2, 3, 4, 5, 12, 6};
        logic exp_st[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_d;
        wb_en      = 1'b1;
        pipe_rd    = 5'd1;
        alu_result = 32'h101;
        mc_valid   = 1'b1;
        mc_rd      = 5'd12;
        mc_data    = 32'hAAA;
        tick();
        mc_valid = 1'b0;
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData, pipe_stall} !== {1'b1, 5'd1, 32'h101, 1'b0}) begin
            n_err++;
            $display("FAIL starve_c0: got we=%b addr=%0d data=%h stall=%b, want 1/1/00000101/0",
                     rf_we, rf_waddr, RegWriteData, pipe_stall);
        end
        for (int i = 0; i < 6; i++) begin
            pipe_rd    = 5'(drv_k[i]);
            alu_result = 32'h100 + 32'(drv_k[i]);
            tick();
            exp_d = (exp_rd[i] == 12) ? 32'hAAA : 32'h100 + 32'(exp_rd[i]);
            n_cmp++;
            if ({rf_we, rf_waddr, RegWriteData, pipe_stall} !== {1'b1, 5'(exp_rd[i]), exp_d, exp_st[i]}) begin
                n_err++;
                $display("FAIL starve[%0d]: got we=%b addr=%0d data=%h stall=%b, want 1/%0d/%h/%b",
                         i, rf_we, rf_waddr, RegWriteData, pipe_stall, exp_rd[i], exp_d, exp_st[i]);
            end
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL starve_once: got we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_full();
        logic exp_rdy[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic exp_st[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int   exp_out[9] = '{20, 20, 20, 20, 20, 13, 14, 15, 0};
        logic [31:0] exp_d;
        pipe_rd    = 5'd20;
        alu_result = 32'h200;
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if ({mc_ready, pipe_stall} !== {exp_rdy[i], exp_st[i]}) begin
                n_err++;
                $display("FAIL full_flags[%0d]: got ready=%b stall=%b, want %b/%b",
                         i, mc_ready, pipe_stall, exp_rdy[i], exp_st[i]);
            end
            wb_en    = (i <= 5);
            mc_valid = (i <= 6);
            mc_rd    = (i == 0) ? 5'd13 : (i == 1) ? 5'd14 : 5'd15;
            mc_data  = (i == 0) ? 32'hB1 : (i == 1) ? 32'hB2 : 32'hB3;
            tick();
            case (exp_out[i])
                13:      exp_d = 32'hB1;
                14:      exp_d = 32'hB2;
                15:      exp_d = 32'hB3;
                default: exp_d = 32'h200;
            endcase
            n_cmp++;
            if (exp_out[i] == 0) begin
                if (rf_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_out[%0d]: got we=%b, want 0", i, rf_we);
                end
            end else if ({rf_we, rf_waddr, RegWriteData} !== {1'b1, 5'(exp_out[i]), exp_d}) begin
                n_err++;
                $display("FAIL full_out[%0d]: got we=%b addr=%0d data=%h, want 1/%0d/%h",
                         i, rf_we, rf_waddr, RegWriteData, exp_out[i], exp_d);
            end
        end
        idle_inputs();
    endtask

    task automatic test_x0_reset();
        mc_valid = 1'b1;
        mc_rd    = 5'd0;
        mc_data  = 32'h77;
        tick();
        mc_valid = 1'b0;
        tick();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL x0_write: got we=%b, want 0", rf_we);
        end
        mc_valid = 1'b1;
        mc_rd    = 5'd6;
        mc_data  = 32'h66;
        tick();
        mc_valid = 1'b0;
        tick();
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData} !== {1'b1, 5'd6, 32'h66}) begin
            n_err++;
            $display("FAIL x0_after: got we=%b addr=%0d data=%h, want 1/6/00000066", rf_we, rf_waddr, RegWriteData);
        end
        tick();
        wb_en      = 1'b1;
        pipe_rd    = 5'd2;
        alu_result = 32'h2;
        mc_valid   = 1'b1;
        mc_rd      = 5'd21;
        mc_data    = 32'hC1;
        tick();
        mc_rd   = 5'd22;
        mc_data = 32'hC2;
        tick();
        mc_valid = 1'b0;
        n_cmp++;
        if (mc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_full: got ready=%b, want 0", mc_ready);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({rf_we, rf_waddr, RegWriteData, pipe_stall, mc_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_async: got we=%b addr=%0d data=%h stall=%b ready=%b, want 0/0/0/0/1",
                     rf_we, rf_waddr, RegWriteData, pipe_stall, mc_ready);
        end
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (rf_we !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stale[%0d]: got we=%b addr=%0d, want we=0", i, rf_we, rf_waddr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mux();
        test_idle_drain();
        test_starvation();
        test_full();
        test_x0_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
